// File: rtl/dual_port_ram_be.sv
`default_nettype none
// ============================================================================
// Module   : dual_port_ram_be
// Purpose  : True dual-port RAM on one clock. Each port has per-byte write
//            enables and its own write mode. An optional output register
//            with a clock enable can follow each port. Same-address
//            collisions always resolve the same way.
// Ports    : clka              - single rising-edge clock for both ports
//            rstb              - synchronous active-high reset; clears the
//                                read registers only, never the array
//            ena/enb           - port enable (no read, no write when 0)
//            wea/web           - per-column write enables
//            addra/addrb       - word address
//            dina/dinb         - write data
//            douta/doutb       - read data
//            regcea/regceb     - output register enable (READ_LATENCY=2)
//            collision         - (DPRAM_COLLISION_DET_EN only) one-cycle
//                                pulse after a same-address cycle in which
//                                at least one port wrote
// Options  : define DPRAM_COLLISION_DET_EN to add the collision detector
// Revision : 1.0 - initial release
// ============================================================================
module dual_port_ram_be #(
    parameter int NB_COL       = 4,
    parameter int COL_WIDTH    = 8,
    parameter int RAM_DEPTH    = 1024,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_MODE_A = 0,
    parameter int WRITE_MODE_B = 0,
    parameter     INIT_FILE    = "",
    localparam int c_w  = NB_COL * COL_WIDTH,
    localparam int c_aw = (RAM_DEPTH <= 2) ? 1 : $clog2(RAM_DEPTH)
) (
    input  logic              clka,
    input  logic              rstb,
    input  logic              ena,
    input  logic [NB_COL-1:0] wea,
    input  logic [c_aw-1:0]   addra,
    input  logic [c_w-1:0]    dina,
    output logic [c_w-1:0]    douta,
    input  logic              regcea,
    input  logic              enb,
    input  logic [NB_COL-1:0] web,
    input  logic [c_aw-1:0]   addrb,
    input  logic [c_w-1:0]    dinb,
    output logic [c_w-1:0]    doutb,
    input  logic              regceb
`ifdef DPRAM_COLLISION_DET_EN
    ,
    output logic              collision
`endif
);

    localparam int c_mode_read_first  = 0;
    localparam int c_mode_write_first = 1;
    localparam int c_mode_no_change   = 2;

    // ------------------------------------------------------------------
    // Parameter checks
    // ------------------------------------------------------------------
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("dual_port_ram_be: READ_LATENCY must be 1 or 2");
    end
    if (WRITE_MODE_A < 0 || WRITE_MODE_A > 2) begin : g_bad_mode_a
        $error("dual_port_ram_be: WRITE_MODE_A must be 0, 1 or 2");
    end
    if (WRITE_MODE_B < 0 || WRITE_MODE_B > 2) begin : g_bad_mode_b
        $error("dual_port_ram_be: WRITE_MODE_B must be 0, 1 or 2");
    end

    // ------------------------------------------------------------------
    // Storage, zero-filled at elaboration
    // ------------------------------------------------------------------
    typedef logic [c_w-1:0] t_mem [RAM_DEPTH];

    function automatic t_mem f_init();
        t_mem m;
        m = '{default: '0};
        return m;
    endfunction

    logic [c_w-1:0] r_ram [RAM_DEPTH] = f_init();

    // Addresses past the end of a non-power-of-2 array are inert.
    logic w_a_ok;
    logic w_b_ok;
    assign w_a_ok = (32'(addra) < RAM_DEPTH);
    assign w_b_ok = (32'(addrb) < RAM_DEPTH);

    // Port B is written after port A inside the same process, so on a
    // column both ports write at the same address, port B's data lands.
    always_ff @(posedge clka) begin
        for (int c = 0; c < NB_COL; c++) begin
            if (ena && wea[c] && w_a_ok)
                r_ram[addra][c*COL_WIDTH +: COL_WIDTH] <= dina[c*COL_WIDTH +: COL_WIDTH];
            if (enb && web[c] && w_b_ok)
                r_ram[addrb][c*COL_WIDTH +: COL_WIDTH] <= dinb[c*COL_WIDTH +: COL_WIDTH];
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    // The merged word only contains this port's own columns, so a reading
    // port always sees the pre-write word even when the other port writes
    // the same address in that cycle.
    function automatic logic [c_w-1:0] f_next_read(
        input int              mode,
        input logic            ok,
        input logic [c_w-1:0]  old_word,
        input logic [c_w-1:0]  din,
        input logic [NB_COL-1:0] we,
        input logic [c_w-1:0]  cur
    );
        logic [c_w-1:0] merged;
        merged = old_word;
        for (int c = 0; c < NB_COL; c++) begin
            if (we[c]) merged[c*COL_WIDTH +: COL_WIDTH] = din[c*COL_WIDTH +: COL_WIDTH];
        end
        case (mode)
            c_mode_write_first: f_next_read = ok ? merged : '0;
            c_mode_no_change:   f_next_read = (|we) ? cur : old_word;
            default:            f_next_read = old_word;
        endcase
    endfunction

    logic [c_w-1:0] w_old_a;
    logic [c_w-1:0] w_old_b;
    logic [c_w-1:0] w_rd_a;
    logic [c_w-1:0] w_rd_b;
    logic [c_w-1:0] r_stage_a;
    logic [c_w-1:0] r_stage_b;

    assign w_old_a = w_a_ok ? r_ram[addra] : '0;
    assign w_old_b = w_b_ok ? r_ram[addrb] : '0;

    always_comb begin
        w_rd_a = f_next_read(WRITE_MODE_A, w_a_ok, w_old_a, dina, wea, r_stage_a);
        w_rd_b = f_next_read(WRITE_MODE_B, w_b_ok, w_old_b, dinb, web, r_stage_b);
    end

    always_ff @(posedge clka) begin
        if (rstb) begin
            r_stage_a <= '0;
            r_stage_b <= '0;
        end else begin
            if (ena) r_stage_a <= w_rd_a;
            if (enb) r_stage_b <= w_rd_b;
        end
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    if (READ_LATENCY == 2) begin : g_lat2
        logic [c_w-1:0] r_out_a;
        logic [c_w-1:0] r_out_b;

        always_ff @(posedge clka) begin
            if (rstb) begin
                r_out_a <= '0;
                r_out_b <= '0;
            end else begin
                if (regcea) r_out_a <= r_stage_a;
                if (regceb) r_out_b <= r_stage_b;
            end
        end

        assign douta = r_out_a;
        assign doutb = r_out_b;
    end else begin : g_lat1
        logic w_unused_regce;
        assign w_unused_regce = regcea ^ regceb;
        assign douta = r_stage_a;
        assign doutb = r_stage_b;
    end

    // ------------------------------------------------------------------
    // Optional same-address collision detector
    // ------------------------------------------------------------------
`ifdef DPRAM_COLLISION_DET_EN
    logic w_coll;
    logic r_collision;

    assign w_coll = ena && enb && (addra == addrb) && ((|wea) || (|web));

    always_ff @(posedge clka) begin
        if (rstb) r_collision <= 1'b0;
        else      r_collision <= w_coll;
    end

    assign collision = r_collision;

`ifndef SYNTHESIS
    always_ff @(posedge clka) begin
        if (w_coll) $display("dual_port_ram_be: warning, collision at address 0x%0h", addra);
    end
`endif
`endif

endmodule
`default_nettype wire

// File: tb/tb_dual_port_ram_be.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_port_ram_be
// Purpose  : Directed self-checking bench for dual_port_ram_be. Several
//            instances with different write modes / read latency share the
//            main stimulus; a small non-power-of-2 instance has its own.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dual_port_ram_be;

    logic        clk = 1'b0;
    logic        rstb;
    logic        ena, enb, regcea, regceb;
    logic [3:0]  wea, web;
    logic [9:0]  addra, addrb;
    logic [31:0] dina, dinb;

    logic [31:0] douta_rf, doutb_rf, douta_wf, doutb_wf;
    logic [31:0] douta_nc, doutb_nc, douta_l2, doutb_l2;

    // non-power-of-2 instance (depth 12, 4-bit address)
    logic        ena2, enb2;
    logic [3:0]  wea2, web2;
    logic [3:0]  addra2, addrb2;
    logic [31:0] dina2, dinb2, douta2, doutb2;

`ifdef DPRAM_COLLISION_DET_EN
    logic coll_rf, coll_wf, coll_nc, coll_l2, coll_np2;
`endif

    always #5 clk = ~clk;

    dual_port_ram_be u_rf (
        .clka(clk), .rstb(rstb),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta_rf), .regcea(regcea),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb_rf), .regceb(regceb)
`ifdef DPRAM_COLLISION_DET_EN
        , .collision(coll_rf)
`endif
    );

    dual_port_ram_be #(.WRITE_MODE_A(1)) u_wf (
        .clka(clk), .rstb(rstb),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta_wf), .regcea(regcea),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb_wf), .regceb(regceb)
`ifdef DPRAM_COLLISION_DET_EN
        , .collision(coll_wf)
`endif
    );

    dual_port_ram_be #(.WRITE_MODE_A(2)) u_nc (
        .clka(clk), .rstb(rstb),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta_nc), .regcea(regcea),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb_nc), .regceb(regceb)
`ifdef DPRAM_COLLISION_DET_EN
        , .collision(coll_nc)
`endif
    );

    dual_port_ram_be #(.READ_LATENCY(2)) u_l2 (
        .clka(clk), .rstb(rstb),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta_l2), .regcea(regcea),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb_l2), .regceb(regceb)
`ifdef DPRAM_COLLISION_DET_EN
        , .collision(coll_l2)
`endif
    );

    dual_port_ram_be #(.RAM_DEPTH(12)) u_np2 (
        .clka(clk), .rstb(rstb),
        .ena(ena2), .wea(wea2), .addra(addra2), .dina(dina2), .douta(douta2), .regcea(1'b1),
        .enb(enb2), .web(web2), .addrb(addrb2), .dinb(dinb2), .doutb(doutb2), .regceb(1'b1)
`ifdef DPRAM_COLLISION_DET_EN
        , .collision(coll_np2)
`endif
    );

    typedef struct {
        logic        rst;
        logic        ena;
        logic [3:0]  wea;
        logic [9:0]  addra;
        logic [31:0] dina;
        logic        enb;
        logic [3:0]  web;
        logic [9:0]  addrb;
        logic [31:0] dinb;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic        exp_c;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(
        input logic rst, input logic ea, input logic [3:0] wa, input logic [9:0] aa,
        input logic [31:0] da, input logic eb, input logic [3:0] wb, input logic [9:0] ab,
        input logic [31:0] db, input logic [31:0] xa, input logic [31:0] xb, input logic xc
    );
        vec_t v;
        v.rst = rst; v.ena = ea; v.wea = wa; v.addra = aa; v.dina = da;
        v.enb = eb; v.web = wb; v.addrb = ab; v.dinb = db;
        v.exp_a = xa; v.exp_b = xb; v.exp_c = xc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic en, input logic [3:0] we, input logic [9:0] a, input logic [31:0] d);
        ena = en; wea = we; addra = a; dina = d;
    endtask

    task automatic set_b(input logic en, input logic [3:0] we, input logic [9:0] a, input logic [31:0] d);
        enb = en; web = we; addrb = a; dinb = d;
    endtask

    task automatic set_a2(input logic en, input logic [3:0] we, input logic [3:0] a, input logic [31:0] d);
        ena2 = en; wea2 = we; addra2 = a; dina2 = d;
    endtask

    initial begin
        rstb = 1'b1; regcea = 1'b1; regceb = 1'b1;
        set_a(0, 4'h0, 10'd0, 32'h0);
        set_b(0, 4'h0, 10'd0, 32'h0);
        set_a2(0, 4'h0, 4'd0, 32'h0);
        enb2 = 1'b0; web2 = 4'h0; addrb2 = 4'd0; dinb2 = 32'h0;

        //                rst A: en we   addr    din            B: en we   addr    din            expA           expB          coll
        vecs.push_back(mk(1,  0, 4'h0, 10'd0,  32'h0,          0, 4'h0, 10'd0,  32'h0,          32'h0,         32'h0,        0));
        vecs.push_back(mk(0,  1, 4'hF, 10'd5,  32'hDEADBEEF,   0, 4'h0, 10'd0,  32'h0,          32'h0,         32'h0,        0));
        vecs.push_back(mk(0,  0, 4'h0, 10'd0,  32'h0,          1, 4'h0, 10'd5,  32'h0,          32'h0,         32'hDEADBEEF, 0));
        vecs.push_back(mk(0,  1, 4'hF, 10'd3,  32'h11223344,   1, 4'h0, 10'd5,  32'h0,          32'h0,         32'hDEADBEEF, 0));
        vecs.push_back(mk(0,  1, 4'h5, 10'd3,  32'hAABBCCDD,   0, 4'h0, 10'd0,  32'h0,          32'h11223344,  32'hDEADBEEF, 0));
        vecs.push_back(mk(0,  1, 4'h0, 10'd3,  32'h0,          1, 4'h0, 10'd3,  32'h0,          32'h11BB33DD,  32'h11BB33DD, 0));
        vecs.push_back(mk(0,  1, 4'hF, 10'd9,  32'hFFFF0000,   1, 4'h3, 10'd9,  32'h0000FFFF,   32'h0,         32'h0,        1));
        vecs.push_back(mk(0,  1, 4'h0, 10'd9,  32'h0,          1, 4'h0, 10'd9,  32'h0,          32'hFFFFFFFF,  32'hFFFFFFFF, 0));
        vecs.push_back(mk(0,  1, 4'hF, 10'd10, 32'h11111111,   1, 4'hC, 10'd10, 32'h22222222,   32'h0,         32'h0,        1));
        vecs.push_back(mk(0,  1, 4'h0, 10'd10, 32'h0,          1, 4'h0, 10'd10, 32'h0,          32'h22221111,  32'h22221111, 0));
        vecs.push_back(mk(0,  1, 4'hF, 10'd11, 32'hCAFEF00D,   0, 4'h0, 10'd0,  32'h0,          32'h0,         32'h22221111, 0));
        vecs.push_back(mk(0,  1, 4'hF, 10'd11, 32'h12345678,   1, 4'h0, 10'd11, 32'h0,          32'hCAFEF00D,  32'hCAFEF00D, 1));
        vecs.push_back(mk(0,  0, 4'h0, 10'd0,  32'h0,          1, 4'h0, 10'd11, 32'h0,          32'hCAFEF00D,  32'h12345678, 0));
        vecs.push_back(mk(0,  1, 4'h0, 10'd5,  32'h0BADBAD0,   0, 4'h0, 10'd0,  32'h0,          32'hDEADBEEF,  32'h12345678, 0));
        vecs.push_back(mk(0,  1, 4'h0, 10'd5,  32'h0,          1, 4'h0, 10'd5,  32'h0,          32'hDEADBEEF,  32'hDEADBEEF, 0));
        vecs.push_back(mk(0,  1, 4'hF, 10'd1,  32'h00000055,   0, 4'h0, 10'd0,  32'h0,          32'h0,         32'hDEADBEEF, 0));
        vecs.push_back(mk(0,  1, 4'h0, 10'd1,  32'h0,          0, 4'h0, 10'd0,  32'h0,          32'h00000055,  32'hDEADBEEF, 0));
        vecs.push_back(mk(1,  1, 4'hF, 10'd2,  32'h00000077,   0, 4'h0, 10'd0,  32'h0,          32'h0,         32'h0,        0));
        vecs.push_back(mk(0,  1, 4'h0, 10'd2,  32'h0,          1, 4'h0, 10'd1,  32'h0,          32'h00000077,  32'h00000055, 0));
        vecs.push_back(mk(0,  0, 4'hF, 10'd5,  32'h0,          1, 4'h0, 10'd2,  32'h0,          32'h00000077,  32'h00000077, 0));
        vecs.push_back(mk(0,  1, 4'h0, 10'd5,  32'h0,          0, 4'h0, 10'd0,  32'h0,          32'hDEADBEEF,  32'h00000077, 0));

        foreach (vecs[i]) begin
            rstb = vecs[i].rst;
            set_a(vecs[i].ena, vecs[i].wea, vecs[i].addra, vecs[i].dina);
            set_b(vecs[i].enb, vecs[i].web, vecs[i].addrb, vecs[i].dinb);
            tick();
            chk($sformatf("vec%0d douta", i), douta_rf, vecs[i].exp_a);
            chk($sformatf("vec%0d doutb", i), doutb_rf, vecs[i].exp_b);
`ifdef DPRAM_COLLISION_DET_EN
            chk($sformatf("vec%0d collision", i), {31'd0, coll_rf}, {31'd0, vecs[i].exp_c});
`endif
        end
        rstb = 1'b0;

        // Write modes on port A: read-first / write-first / no-change
        set_b(0, 4'h0, 10'd0, 32'h0);
        set_a(1, 4'hF, 10'd7, 32'h00000001); tick();
        set_a(1, 4'hF, 10'd4, 32'h0000ABCD); tick();
        set_a(1, 4'h0, 10'd4, 32'h0);        tick();
        chk("mode prep rf", douta_rf, 32'h0000ABCD);
        chk("mode prep wf", douta_wf, 32'h0000ABCD);
        chk("mode prep nc", douta_nc, 32'h0000ABCD);
        set_a(1, 4'hF, 10'd7, 32'h00000002); tick();
        chk("read-first douta", douta_rf, 32'h00000001);
        chk("write-first douta", douta_wf, 32'h00000002);
        chk("no-change douta", douta_nc, 32'h0000ABCD);
        set_a(1, 4'h0, 10'd7, 32'h0); tick();
        chk("no-change wrote", douta_nc, 32'h00000002);
        set_a(1, 4'hA, 10'd7, 32'hAA00BB00); tick();
        chk("write-first merge", douta_wf, 32'hAA00BB02);
        chk("read-first old", douta_rf, 32'h00000002);

        // READ_LATENCY=2 output register gating
        set_a(0, 4'h0, 10'd0, 32'h0);
        rstb = 1'b1; tick();
        chk("lat2 reset doutb", doutb_l2, 32'h0);
        rstb = 1'b0;
        regceb = 1'b0;
        set_b(1, 4'h0, 10'd1, 32'h0); tick();
        chk("lat2 hold1", doutb_l2, 32'h0);
        tick();
        chk("lat2 hold2", doutb_l2, 32'h0);
        regceb = 1'b1; tick();
        chk("lat2 load", doutb_l2, 32'h00000055);
        set_b(1, 4'h0, 10'd4, 32'h0);
        regcea = 1'b1;
        set_a(1, 4'h0, 10'd4, 32'h0); tick();
        chk("lat2 pipe stage", doutb_l2, 32'h00000055);
        tick();
        chk("lat2 pipe out b", doutb_l2, 32'h0000ABCD);
        chk("lat2 pipe out a", douta_l2, 32'h0000ABCD);
        rstb = 1'b1; tick();
        chk("lat2 reset again", doutb_l2, 32'h0);
        rstb = 1'b0;
        set_a(0, 4'h0, 10'd0, 32'h0);
        set_b(0, 4'h0, 10'd0, 32'h0);

        // Non-power-of-2 depth: addresses 12..15 are inert
        set_a2(1, 4'hF, 4'd13, 32'h99999999); tick();
        set_a2(1, 4'hF, 4'd11, 32'h0000005A); tick();
        set_a2(1, 4'h0, 4'd11, 32'h0);        tick();
        chk("np2 valid read", douta2, 32'h0000005A);
        set_a2(1, 4'h0, 4'd13, 32'h0);        tick();
        chk("np2 oob read", douta2, 32'h0);
        set_a2(1, 4'h0, 4'd5, 32'h0);         tick();
        chk("np2 no alias 5", douta2, 32'h0);
        set_a2(1, 4'h0, 4'd1, 32'h0);         tick();
        chk("np2 no alias 1", douta2, 32'h0);
        set_a2(0, 4'h0, 4'd0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
